spmv_row_reducer: RTL and testbench

Row-reduction stage of the SpMV datapath. It consumes NUM_CH-lane beats of per-element products, which are value times gathered x, produced downstream of the SPM channel outputs. It segments them into matrix rows using a stream of row lengths and emits one reduced y value per row, tagged with its row index. Lanes are scanned serially, one lane per cycle, trading throughput for a small, simple reduction path.

---
 rtl/spmv_row_reducer.sv | 185 ++++++++++++++++++
 tb/tb_spmv_row_reducer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_reducer.sv
// spmv_row_reducer
//   Row-reduction stage of the SpMV datapath. Takes NUM_CH-lane beats of
//   per-element products, splits them into rows using a stream of row
//   lengths, and emits one summed y value per row tagged with its index.
//   Lanes are scanned one per cycle from a single-entry beat buffer.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   spmv_init, nr     start/abort pulse; nr = number of rows, sampled on init
//   prod_val/rdy      product beat handshake; prod_data lane i at
//   prod_data/mask    [(i+1)*DATA_W-1 : i*DATA_W], mask bit 1 = real nonzero
//   len_val/rdy/data  row-length handshake (nonzero count of the next row)
//   y_val/rdy         result handshake; y_data = row sum, y_row = row index
//   done              all nr rows have been emitted
//   overrun           sticky: a real product lane showed up after the last row
module spmv_row_reducer #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32,
  parameter int ROW_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spmv_init,
  input  logic [ROW_W-1:0]         nr,
  input  logic                     prod_val,
  output logic                     prod_rdy,
  input  logic [NUM_CH*DATA_W-1:0] prod_data,
  input  logic [NUM_CH-1:0]        prod_mask,
  input  logic                     len_val,
  output logic                     len_rdy,
  input  logic [DATA_W-1:0]        len_data,
  output logic                     y_val,
  input  logic                     y_rdy,
  output logic [DATA_W-1:0]        y_data,
  output logic [ROW_W-1:0]         y_row,
  output logic                     done,
  output logic                     overrun
);

  localparam int LP_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LP_W-1:0] LAST_LP = LP_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LEN,
    S_ACCUM,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_CH*DATA_W-1:0] buf_data_reg;
  logic [NUM_CH-1:0]        buf_mask_reg;
  logic [LP_W-1:0]          lp_reg;
  logic                     full_reg;
  logic [DATA_W-1:0]        acc_reg;
  logic [DATA_W-1:0]        rem_reg;
  logic [ROW_W-1:0]         row_idx_reg;
  logic [ROW_W-1:0]         nr_reg;
  logic                     overrun_reg;

  logic [DATA_W-1:0] buf_lane [NUM_CH];
  logic [NUM_CH-1:0] hi_mask;
  logic [DATA_W-1:0] lane_data;
  logic              lane_mask;
  logic              consume;
  logic              last_lane;
  logic              row_end;
  logic              pending;
  logic              last_row;
  logic              prod_fire;
  logic              len_fire;
  logic              y_fire;

  // Lane view of the buffer, plus the set of real lanes not yet scanned
  // (lane index at or above the pointer).
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign buf_lane[gi] = buf_data_reg[gi*DATA_W +: DATA_W];
      assign hi_mask[gi]  = buf_mask_reg[gi] && (LP_W'(gi) >= lp_reg);
    end
  endgenerate

  assign lane_data = buf_lane[lp_reg];
  assign lane_mask = buf_mask_reg[lp_reg];
  assign consume   = (state_reg == S_ACCUM) && full_reg;
  assign last_lane = (lp_reg == LAST_LP);
  // rem is never zero in ACCUM: zero-length rows go straight to EMIT.
  assign row_end   = consume && lane_mask && (rem_reg == DATA_W'(1));
  assign pending   = full_reg && (|hi_mask);
  assign last_row  = ((row_idx_reg + ROW_W'(1)) == nr_reg);
  assign prod_fire = prod_val && prod_rdy;
  assign len_fire  = len_val && len_rdy;
  assign y_fire    = y_val && y_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; init overrides any handshake in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (spmv_init) begin
      state_next = (nr == '0) ? S_DONE : S_LOAD_LEN;
    end else begin
      case (state_reg)
        S_LOAD_LEN: if (len_fire) state_next = (len_data == '0) ? S_EMIT : S_ACCUM;
        S_ACCUM:    if (row_end)  state_next = S_EMIT;
        S_EMIT:     if (y_fire)   state_next = last_row ? S_DONE : S_LOAD_LEN;
        default:    state_next = state_reg;
      endcase
    end
  end

  // Outputs. The buffer takes a beat when empty, when its last lane leaves
  // this cycle (no bubble between beats), or always in DONE (discard).
  always_comb begin
    prod_rdy = (state_reg != S_IDLE) &&
               (!full_reg || (consume && last_lane) || (state_reg == S_DONE));
    len_rdy  = (state_reg == S_LOAD_LEN);
    y_val    = (state_reg == S_EMIT);
    done     = (state_reg == S_DONE);
    y_data   = acc_reg;
    y_row    = row_idx_reg;
    overrun  = overrun_reg;
  end

  // Datapath: beat buffer, accumulator, row bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_data_reg <= '0;
      buf_mask_reg <= '0;
      lp_reg       <= '0;
      full_reg     <= 1'b0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      row_idx_reg  <= '0;
      nr_reg       <= '0;
      overrun_reg  <= 1'b0;
    end else if (spmv_init) begin
      full_reg    <= 1'b0;
      lp_reg      <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      row_idx_reg <= '0;
      overrun_reg <= 1'b0;
      nr_reg      <= nr;
    end else begin
      if (len_fire) begin
        rem_reg <= len_data;
        acc_reg <= '0;
      end
      if (consume) begin
        if (lane_mask) begin
          acc_reg <= acc_reg + lane_data;
          rem_reg <= rem_reg - DATA_W'(1);
        end
        lp_reg <= lp_reg + LP_W'(1);
        if (last_lane) full_reg <= 1'b0;
      end
      if (y_fire) row_idx_reg <= row_idx_reg + ROW_W'(1);
      // Leftover real lanes after the final row flag an overrun on the
      // first DONE cycle; the buffer is then drained.
      if (state_reg == S_DONE) begin
        full_reg <= 1'b0;
        if (pending) overrun_reg <= 1'b1;
      end
      // A refill wins over the last-lane empty above.
      if (prod_fire) begin
        if (state_reg == S_DONE) begin
          if (|prod_mask) overrun_reg <= 1'b1;
        end else begin
          buf_data_reg <= prod_data;
          buf_mask_reg <= prod_mask;
          lp_reg       <= '0;
          full_reg     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spmv_row_reducer.sv
// Self-checking bench for spmv_row_reducer: table of single-beat matrices
// plus hand-written sequences for beat spanning, backpressure, overrun,
// abort and mid-operation reset. y results are checked via a scoreboard.
module tb_spmv_row_reducer;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 32;
  localparam int ROW_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     spmv_init;
  logic [ROW_W-1:0]         nr;
  logic                     prod_val;
  logic                     prod_rdy;
  logic [NUM_CH*DATA_W-1:0] prod_data;
  logic [NUM_CH-1:0]        prod_mask;
  logic                     len_val;
  logic                     len_rdy;
  logic [DATA_W-1:0]        len_data;
  logic                     y_val;
  logic                     y_rdy;
  logic [DATA_W-1:0]        y_data;
  logic [ROW_W-1:0]         y_row;
  logic                     done;
  logic                     overrun;

  always #5 clk = ~clk;

  spmv_row_reducer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .nr(nr),
    .prod_val(prod_val), .prod_rdy(prod_rdy), .prod_data(prod_data),
    .prod_mask(prod_mask), .len_val(len_val), .len_rdy(len_rdy),
    .len_data(len_data), .y_val(y_val), .y_rdy(y_rdy), .y_data(y_data),
    .y_row(y_row), .done(done), .overrun(overrun)
  );

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        mask;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
  } exp_t;

  typedef struct packed {
    logic [31:0]      nr;
    logic [2:0][31:0] lens;
    logic [15:0]      mask;
    logic [31:0]      base;
    logic [2:0][31:0] ys;
    logic             ovr;
  } vec_t;

  beat_t             beat_q[$];
  logic [DATA_W-1:0] len_q[$];
  exp_t              exp_q[$];

  int checks = 0;
  int errors = 0;

  logic prod_fire_q = 1'b0;
  logic len_fire_q  = 1'b0;
  logic y_fire_q    = 1'b0;
  logic [DATA_W-1:0] y_data_q;
  logic [ROW_W-1:0]  y_row_q;

  // Handshakes as seen at the clock edge, examined on the next falling edge.
  always @(posedge clk) begin
    prod_fire_q <= prod_val && prod_rdy;
    len_fire_q  <= len_val && len_rdy;
    y_fire_q    <= y_val && y_rdy;
    y_data_q    <= y_data;
    y_row_q     <= y_row;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Product beat driver
  initial begin
    beat_t b;
    prod_val  = 1'b0;
    prod_data = '0;
    prod_mask = '0;
    forever begin
      @(negedge clk);
      if (prod_fire_q) prod_val = 1'b0;
      if (!prod_val && beat_q.size() > 0) begin
        b = beat_q.pop_front();
        prod_data = b.data;
        prod_mask = b.mask;
        prod_val  = 1'b1;
      end
    end
  end

  // Row length driver
  initial begin
    len_val  = 1'b0;
    len_data = '0;
    forever begin
      @(negedge clk);
      if (len_fire_q) len_val = 1'b0;
      if (!len_val && len_q.size() > 0) begin
        len_data = len_q.pop_front();
        len_val  = 1'b1;
      end
    end
  end

  // Result monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (y_fire_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL y_unexpected actual row=%0d data=%0h required=no result", y_row_q, y_data_q);
        end else begin
          e = exp_q.pop_front();
          $display("y row=%0d data=%0h (expect row=%0d data=%0h)", y_row_q, y_data_q, e.row, e.data);
          chk("y_data", y_data_q, e.data);
          chk("y_row", y_row_q, e.row);
        end
      end
    end
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [NUM_CH*DATA_W-1:0] mk_data(input logic [31:0] base);
    logic [NUM_CH*DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = base + 32'(i);
    return d;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] fill_data(input logic [31:0] v);
    logic [NUM_CH*DATA_W-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = v;
    return d;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] n, l0, l1, l2, input logic [15:0] m,
                                  input logic [31:0] b, y0, y1, y2, input logic ov);
    vec_t t;
    t.nr = n;
    t.lens[0] = l0; t.lens[1] = l1; t.lens[2] = l2;
    t.mask = m;
    t.base = b;
    t.ys[0] = y0; t.ys[1] = y1; t.ys[2] = y2;
    t.ovr = ov;
    return t;
  endfunction

  task automatic push_beat(input logic [NUM_CH*DATA_W-1:0] d, input logic [NUM_CH-1:0] m);
    beat_t b;
    b.data = d;
    b.mask = m;
    beat_q.push_back(b);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] r);
    exp_t e;
    e.data = d;
    e.row  = r;
    exp_q.push_back(e);
  endtask

  // Pulse init for one cycle; first LOAD_LEN (or DONE for nr=0) follows at once.
  task automatic do_init(input logic [31:0] n);
    @(negedge clk);
    spmv_init = 1'b1;
    nr        = n;
    @(negedge clk);
    spmv_init = 1'b0;
    if (n == 0) chk("init_done", done, 1);
    else        chk("init_len_rdy", len_rdy, 1);
    chk("init_ovr_clear", overrun, 0);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done, 1);
    repeat (2) @(negedge clk);
    chk({name, "_y_drained"}, exp_q.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [NUM_CH*DATA_W-1:0] d;
    int t_len, t_y, n;

    vecs[0] = mk_vec(2, 3, 2, 0, 16'h001F, 32'd1,          32'd6,          32'd9,   32'd0, 1'b0);
    vecs[1] = mk_vec(3, 0, 1, 0, 16'h0001, 32'd7,          32'd0,          32'd7,   32'd0, 1'b0);
    vecs[2] = mk_vec(1, 2, 0, 0, 16'h0505, 32'd10,         32'd22,         32'd0,   32'd0, 1'b1);
    vecs[3] = mk_vec(2, 1, 1, 0, 16'h8001, 32'd100,        32'd100,        32'd115, 32'd0, 1'b0);
    vecs[4] = mk_vec(1, 4, 0, 0, 16'hF000, 32'h7FFF_FFFF,  32'h32,         32'd0,   32'd0, 1'b0);
    vecs[5] = mk_vec(2, 2, 1, 0, 16'h0013, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd3,   32'd0, 1'b0);

    rst_n     = 1'b0;
    spmv_init = 1'b0;
    nr        = '0;
    y_rdy     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_prod_rdy", prod_rdy, 0);
    chk("rst_len_rdy", len_rdy, 0);
    chk("rst_y_val", y_val, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_row", y_row, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_prod_rdy", prod_rdy, 0);
    chk("idle_len_rdy", len_rdy, 0);
    #1;

    // Table-driven single-beat matrices
    for (int v = 0; v < 6; v++) begin
      do_init(vecs[v].nr);
      push_beat(mk_data(vecs[v].base), vecs[v].mask);
      for (int r = 0; r < int'(vecs[v].nr); r++) begin
        len_q.push_back(vecs[v].lens[r]);
        push_exp(vecs[v].ys[r], 32'(r));
      end
      wait_done($sformatf("vec%0d", v), 300);
      chk($sformatf("vec%0d_overrun", v), overrun, vecs[v].ovr);
    end

    // Row spanning two beats, no bubble: 20 lanes after the length handshake.
    do_init(1);
    push_beat(fill_data(32'd1), 16'hFFFF);
    push_beat(fill_data(32'd1), 16'h000F);
    len_q.push_back(32'd20);
    push_exp(32'd20, 32'd0);
    t_len = -1;
    t_y   = -1;
    for (int i = 0; i < 80 && t_y < 0; i++) begin
      @(negedge clk);
      if (len_fire_q && t_len < 0) t_len = i;
      if (y_val && t_y < 0) t_y = i;
    end
    chk("span_latency", 64'(t_y - t_len), 64'd20);
    wait_done("span", 50);
    chk("span_overrun", overrun, 0);

    // Backpressure on y with wrapping sum 0xFFFFFFFF + 2 = 1
    y_rdy = 1'b0;
    do_init(1);
    d = '0;
    d[15*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
    push_beat(d, 16'h8000);
    d = '0;
    d[0 +: DATA_W]      = 32'd2;
    d[DATA_W +: DATA_W] = 32'd5;
    push_beat(d, 16'h0003);
    push_beat(fill_data(32'h55), 16'h0000);
    len_q.push_back(32'd2);
    push_exp(32'd1, 32'd0);
    n = 0;
    while (!y_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_y_val_rise", y_val, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_y_val", y_val, 1);
      chk("stall_y_data", y_data, 32'd1);
      chk("stall_y_row", y_row, 0);
      chk("stall_prod_rdy", prod_rdy, 0);
    end
    y_rdy = 1'b1;
    wait_done("stall", 50);
    chk("stall_overrun", overrun, 1);
    chk("stall_beat_drained", prod_val, 0);

    // Zero-length single row, then a real lane after done
    do_init(1);
    len_q.push_back(32'd0);
    push_exp(32'd0, 32'd0);
    wait_done("len0", 50);
    chk("len0_overrun", overrun, 0);
    d = '0;
    d[8*DATA_W +: DATA_W] = 32'd9;
    push_beat(d, 16'h0100);
    repeat (4) @(negedge clk);
    chk("late_overrun", overrun, 1);
    chk("late_y_val", y_val, 0);
    chk("late_done", done, 1);
    do_init(0);

    // Abort mid-ACCUM with nr=0
    do_init(1);
    len_q.push_back(32'd5);
    d = '0;
    d[0 +: DATA_W] = 32'd3;
    push_beat(d, 16'h0001);
    repeat (25) @(negedge clk);
    chk("stuck_done", done, 0);
    chk("stuck_y_val", y_val, 0);
    chk("stuck_len_rdy", len_rdy, 0);
    do_init(0);
    chk("abort_len_rdy", len_rdy, 0);

    // Reset in the middle of a row
    do_init(1);
    len_q.push_back(32'd3);
    d = '0;
    d[0 +: DATA_W] = 32'd4;
    push_beat(d, 16'h0001);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_prod_rdy", prod_rdy, 0);
    chk("mrst_len_rdy", len_rdy, 0);
    chk("mrst_y_val", y_val, 0);
    chk("mrst_y_data", y_data, 0);
    chk("mrst_y_row", y_row, 0);
    chk("mrst_done", done, 0);
    chk("mrst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_idle_prod_rdy", prod_rdy, 0);
    chk("mrst_no_pending_y", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
